// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store path: access sizes, FSM states,
// alignment and narrowing-loss rules.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERR
    } state_t;

    // Size 2'b11 has no legal alignment, so it always reports misaligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when sign-extending the stored slice would not give back the source.
    function automatic logic narrow_lost(input logic [31:0] data, input logic [1:0] size);
        logic lost;
        case (size)
            SZ_BYTE: lost = (data[31:8] != {24{data[7]}});
            SZ_HALF: lost = (data[31:16] != {16{data[15]}});
            default: lost = 1'b0;
        endcase
        return lost;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the addressed byte or halfword lane of a memory word with the
// low bits of the store data, leaving every other lane untouched.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[8*addr_lo +: 8] = data[7:0];
            SZ_HALF: begin
                if (addr_lo[1])
                    merged[31:16] = data[15:0];
                else
                    merged[15:0] = data[15:0];
            end
            SZ_WORD: merged = data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/unidade_store.sv
// Store unit: narrows a register value to byte/halfword/word and writes it to
// word-organised memory, using read-modify-write for sub-word stores.
module unidade_store
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err,
    output logic              trunc_ovf
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged;
    logic              accept;

    assign accept = req_valid && (state == IDLE);

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Request fields are captured once at accept and held for the whole operation,
    // which keeps mem_addr stable through READ, MERGE and WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_BYTE;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            data_q <= req_data;
            size_q <= req_size;
            if (req_size == SZ_WORD)
                wdata_q <= req_data;
        end else if (state == MERGE) begin
            wdata_q <= merged;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_aligned(req_size, req_addr[1:0]))
                        next_state = ERR;
                    else if (req_size == SZ_WORD)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = MERGE;
            MERGE:   next_state = WRITE;
            WRITE:   next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every output is a decode of the state register plus held request fields.
    always_comb begin
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        trunc_ovf = 1'b0;
        case (state)
            IDLE:  req_ready = 1'b1;
            READ:  mem_rd_en = 1'b1;
            WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
                trunc_ovf = narrow_lost(data_q, size_q);
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule
